// File: rtl/mpsoc_wb_ram_port.sv
// Wishbone B3 slave front-end for the single-port generic RAM with 1-cycle registered reads.
// Classic and incrementing-burst cycles become one RAM access per acknowledged beat.
module mpsoc_wb_ram_port #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [AW+1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic [3:0]    ram_we,
  output logic [DW-1:0] ram_din,
  output logic [AW-1:0] ram_waddr,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam logic [2:0]  CTI_INC = 3'b010;
  localparam logic [2:0]  CTI_EOB = 3'b111;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        state_r;
  logic          ack_r;
  logic          err_r;
  logic          req_s;
  logic [AW-1:0] word_s;
  logic [AW-1:0] wrap_mask_s;
  logic [AW-1:0] next_word_s;
  logic          oor_s;
  logic          next_oor_s;
  logic          unused_s;

  assign req_s      = wb_cyc_i & wb_stb_i;
  assign word_s     = wb_adr_i[AW+1:2];
  assign oor_s      = ({1'b0, word_s} >= DEPTH_W);
  assign next_oor_s = ({1'b0, next_word_s} >= DEPTH_W);
  assign unused_s   = ^wb_adr_i[1:0];

  assign wb_ack_o  = ack_r;
  assign wb_err_o  = err_r;
  assign wb_dat_o  = ram_dout;
  assign ram_din   = wb_dat_i;
  assign ram_waddr = word_s;

  // Burst address successor: bits inside the wrap mask count, bits above it hold
  always_comb begin
    case (wb_bte_i)
      2'b01:   wrap_mask_s = AW'(4'd3);
      2'b10:   wrap_mask_s = AW'(4'd7);
      2'b11:   wrap_mask_s = AW'(4'd15);
      default: wrap_mask_s = '1;
    endcase
    next_word_s = (word_s & ~wrap_mask_s) | ((word_s + AW'(1'b1)) & wrap_mask_s);
  end

  // Byte enables fire only in an acked beat with the request still present
  always_comb begin
    if (ack_r && req_s && wb_we_i && !wb_rst_i) begin
      ram_we = wb_sel_i;
    end else begin
      ram_we = 4'b0000;
    end
  end

  // Prefetch the following beat while a burst is streaming so data meets each ack
  always_comb begin
    if ((state_r == BURST) && ack_r && (wb_cti_i == CTI_INC)) begin
      ram_raddr = next_word_s;
    end else begin
      ram_raddr = word_s;
    end
  end

  // Ack/err sequencing for classic and incrementing-burst cycles
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= IDLE;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s && !ack_r && !err_r && oor_s) begin
            ack_r <= 1'b0;
            err_r <= 1'b1;
          end else if (req_s && !ack_r && !err_r) begin
            ack_r <= 1'b1;
            err_r <= 1'b0;
            if (wb_cti_i == CTI_INC) begin
              state_r <= BURST;
            end
          end else begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
          end
        end
        BURST: begin
          if (!req_s || (wb_cti_i == CTI_EOB)) begin
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            state_r <= IDLE;
          end else if (next_oor_s) begin
            ack_r   <= 1'b0;
            err_r   <= 1'b1;
            state_r <= IDLE;
          end else begin
            ack_r <= 1'b1;
            err_r <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mpsoc_wb_ram_port.md
Name: mpsoc_wb_ram_port

Overview:
Wishbone B3 slave front-end that drives the team's single-port generic RAM.
- Drives the RAM's byte write-enables, write data and write/read addresses, and consumes its 1-cycle registered read data.
- Converts classic and registered-feedback burst Wishbone cycles into RAM accesses.
- Sits between the interconnect and each on-chip RAM instance in the MPSoC.

Parameters:
DEPTH, 256, RAM depth in 32-bit words; need not be a power of two
AW, $clog2(DEPTH), RAM word-address width
DW, 32, data width; only 32 is supported

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
wb_adr_i  in  AW+2  byte address; bits [1:0] ignored
wb_dat_i  in  DW  write data
wb_sel_i  in  4  byte selects
wb_we_i  in  1  write strobe
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst
wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
wb_dat_o  out  DW  read data (= ram_dout)
wb_ack_o  out  1  acknowledge
wb_err_o  out  1  error (address out of range)
ram_we  out  4  RAM byte write-enables
ram_din  out  DW  RAM write data (= wb_dat_i)
ram_waddr  out  AW  RAM write word address
ram_raddr  out  AW  RAM read word address
ram_dout  in  DW  RAM registered read data

Behaviour:
- Reset:
  - wb_ack_o=0, wb_err_o=0, FSM=IDLE; ram_we=0 while wb_rst_i is high.
  - wb_dat_o is not reset and is only meaningful when ack=1.
- Definitions:
  - req = wb_cyc_i & wb_stb_i
  - word = wb_adr_i[AW+1:2]
  - oor = (word >= DEPTH)
- FSM states:
  - IDLE: no ack pending.
  - BURST: ack streaming.
- IDLE transitions:
  - req & !ack & !err & oor -> err=1 next cycle (one cycle only), stay IDLE.
  - req & !ack & !err & !oor -> ack=1 next cycle.
    - If wb_cti_i==010, go to BURST.
    - Otherwise (classic or 111) ack lasts exactly one cycle, then ack=0 for at least one cycle.
- BURST transitions (ack=1 in the current cycle):
  - !req -> ack=0 next cycle, IDLE.
  - wb_cti_i==111 -> ack=0 next cycle, IDLE.
  - next word oor -> ack=0 and err=1 next cycle, IDLE.
  - Otherwise ack stays 1: one beat per cycle, zero wait states.
- Writes:
  - ram_we = wb_sel_i when (wb_ack_o_next & ... is NOT used) — the enable is wb_ack_o & req & wb_we_i; otherwise 0.
  - The write lands in the ack cycle, using the current wb_adr_i and wb_dat_i.
  - ram_waddr = word.
  - Exactly one write per acked beat. No write on err or on unacked cycles.
- Read address (combinational):
  - ram_raddr = next_word when (state==BURST & ack & wb_cti_i==010); otherwise word.
  - Read data therefore arrives one cycle later, coincident with each ack.
  - Classic read latency: request at cycle n, ack and data valid at n+1.
- next_word (byte address +4, wrapped per wb_bte_i):
  - linear: word+1, modulo 2^AW.
  - wrap4: bits [3:2] increment, upper bits held.
  - wrap8: bits [4:2] increment, upper bits held.
  - wrap16: bits [5:2] increment, upper bits held.
- Read-during-write, same word: read returns the old data (RAM semantics). A burst read immediately after a write to the same word sees the new data.
- Simultaneous events:
  - wb_rst_i overrides everything.
  - cyc dropping in the same cycle as ack: that beat's write still occurs (req was high); FSM returns to IDLE next cycle.
- Reset mid-burst: ack=0 the next cycle, no further writes, FSM=IDLE.
- wb_cti_i/wb_bte_i are sampled every beat; a master may switch bte mid-burst and the change takes effect on the next address.

Test Plan:
- Classic write then read: write 0xDEADBEEF to 0x10 (sel=1111), then read 0x10 -> ack one cycle after each request; read returns 0xDEADBEEF; ack low for one cycle between transfers.
- Byte lanes: write 0x11223344, then write sel=0100 dat=0x00AA0000, then read -> 0x11AA3344.
- Linear burst read of 4 beats from 0x20 (cti 010,010,010,111) over memory preloaded so mem[i]=i -> ack high 4 consecutive cycles; data 8,9,10,11; ack low on the 5th cycle.
- Wrap4 burst write starting at 0x1C (word 7) with data A,B,C,D -> words 7,4,5,6 hold A,B,C,D; word 8 unchanged.
- Out of range, DEPTH=200: classic read at byte 0x320 (word 200) -> err=1 for one cycle, ack=0, no write. Linear burst from word 198 -> acks for words 198 and 199, then err on the third beat.
- Abort: deassert wb_cyc_i after the 2nd ack of an 8-beat write burst, and separately assert wb_rst_i mid-burst -> ack=0 next cycle; only beats 1-2 are written; next request is serviced from IDLE with 1-cycle latency.
